// File: rtl/uart_pkg.sv
// uart_pkg: baud default, frame size and FSM states shared by the transmit and receive UARTs.
package uart_pkg;
    localparam int CLKS_PER_BIT = 434;
    localparam int FRAME_BITS = 10;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/result_uart_tx_if.sv
// result_uart_tx_if: request and serial-line signals between the processing unit and the back-channel UART.
interface result_uart_tx_if;
    logic       send;
    logic [7:0] result_data;
    logic       overflow;
    logic       tx;
    logic       busy;
    logic       done;
    modport master (output send, result_data, overflow, input tx, busy, done);
    modport slave (input send, result_data, overflow, output tx, busy, done);
endinterface

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: bit timer counting 0..CLKS_PER_BIT-1 with a tick at terminal count.
module uart_baud_counter import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int W = $clog2(CLKS_PER_BIT);
    logic [W-1:0] cnt_q, cnt_d;
    assign tick_o = en_i && cnt_q == W'(CLKS_PER_BIT - 1);
    always_comb cnt_d = (clr_i || tick_o) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/result_uart_tx.sv
// result_uart_tx: sends the latched result byte then a status byte as two back-to-back 8N1 frames.
module result_uart_tx import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
    input logic clk,
    input logic rst,
    result_uart_tx_if.slave bus
);
    state_t     state_q;
    logic [7:0] sh_q, b1_q;
    logic [2:0] bit_q;
    logic       bi_q, tx_q, busy_q, done_q, tick;
    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q != IDLE),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            b1_q    <= '0;
            bit_q   <= '0;
            bi_q    <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.send) begin
                    state_q <= START;
                    sh_q    <= bus.result_data;
                    b1_q    <= {7'b0, bus.overflow};
                    bi_q    <= 1'b0;
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b1;
                end
                START: if (tick) begin
                    state_q <= DATA;
                    bit_q   <= '0;
                    tx_q    <= sh_q[0];
                    sh_q    <= sh_q >> 1;
                end
                DATA: if (tick) begin
                    if (bit_q == 3'd7) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        bit_q <= bit_q + 3'd1;
                        tx_q  <= sh_q[0];
                        sh_q  <= sh_q >> 1;
                    end
                end
                STOP: if (tick) begin
                    // status frame follows immediately, no idle bit between frames
                    if (!bi_q) begin
                        state_q <= START;
                        bi_q    <= 1'b1;
                        sh_q    <= b1_q;
                        tx_q    <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: checks both frames bit-by-bit against a frame model at CLKS_PER_BIT 4 and 2.
module tb_result_uart_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    result_uart_tx_if if4 ();
    result_uart_tx_if if2 ();
    result_uart_tx #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    result_uart_tx #(.CLKS_PER_BIT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    int checks = 0;
    int passed = 0;
    typedef struct {
        int         cpb;
        logic [7:0] data;
        logic       ovf;
        logic [7:0] exp_b1;
    } vec_t;
    vec_t tbl [4];
    task automatic chk(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask
    // line level at frame slot k (0..19): start 0, 8 data bits LSB first, stop 1, for each byte
    function automatic logic line_bit(logic [7:0] b0, logic [7:0] b1, int k);
        logic [7:0] bv;
        int j;
        bv = (k < 10) ? b0 : b1;
        j = k % 10;
        return (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : bv[j-1];
    endfunction
    function automatic logic [2:0] outs(int cpb);
        return (cpb == 4) ? {if4.tx, if4.busy, if4.done} : {if2.tx, if2.busy, if2.done};
    endfunction
    task automatic drive(int cpb, logic s, logic [7:0] d, logic o);
        if (cpb == 4) begin if4.send = s; if4.result_data = d; if4.overflow = o; end
        else begin if2.send = s; if2.result_data = d; if2.overflow = o; end
    endtask
    task automatic set_send(int cpb, logic s);
        if (cpb == 4) if4.send = s;
        else if2.send = s;
    endtask
    task automatic start(int cpb, logic [7:0] d, logic o);
        @(negedge clk);
        drive(cpb, 1'b1, d, o);
    endtask
    task automatic watch(int cpb, logic [7:0] b0, logic [7:0] b1, bit hold, string tag);
        int n, bad_tx, bad_busy, k, j;
        logic [7:0] d0, d1;
        logic [2:0] o;
        n = 20 * cpb;
        bad_tx = 0; bad_busy = 0; d0 = '0; d1 = '0;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            o = outs(cpb);
            if (i == 0 && !hold) set_send(cpb, 1'b0);
            if (i < n) begin
                if (o[2] !== line_bit(b0, b1, i / cpb)) bad_tx++;
                if (o[1] !== 1'b1 || o[0] !== 1'b0) bad_busy++;
                if (i % cpb == cpb / 2) begin
                    k = i / cpb;
                    j = k % 10;
                    if (j >= 1 && j <= 8) begin
                        if (k < 10) d0[j-1] = o[2];
                        else d1[j-1] = o[2];
                    end
                end
            end else begin
                chk($sformatf("%s done_pulse", tag), int'(o[0]), 1);
                chk($sformatf("%s busy_end", tag), int'(o[1]), 0);
                chk($sformatf("%s tx_end", tag), int'(o[2]), 1);
            end
        end
        chk($sformatf("%s tx_wave_errs", tag), bad_tx, 0);
        chk($sformatf("%s busy_errs", tag), bad_busy, 0);
        chk($sformatf("%s decode_b0", tag), int'(d0), int'(b0));
        chk($sformatf("%s decode_b1", tag), int'(d1), int'(b1));
        if (!hold) begin
            @(negedge clk);
            o = outs(cpb);
            chk($sformatf("%s done_one_cycle", tag), int'(o[0]), 0);
            chk($sformatf("%s idle_busy", tag), int'(o[1]), 0);
        end
    endtask
    initial begin
        logic [2:0] o;
        int errs;
        logic [7:0] rd;
        logic ro;
        int cpb;
        tbl[0] = '{4, 8'hA5, 1'b0, 8'h00};
        tbl[1] = '{4, 8'hFF, 1'b1, 8'h01};
        tbl[2] = '{2, 8'h3C, 1'b0, 8'h00};
        tbl[3] = '{2, 8'h81, 1'b1, 8'h01};
        drive(4, 1'b0, 8'h00, 1'b0);
        drive(2, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        o = outs(4);
        chk("reset4 tx/busy/done", int'(o), 3'b100);
        o = outs(2);
        chk("reset2 tx/busy/done", int'(o), 3'b100);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        foreach (tbl[i]) begin
            start(tbl[i].cpb, tbl[i].data, tbl[i].ovf);
            watch(tbl[i].cpb, tbl[i].data, tbl[i].exp_b1, 1'b0, $sformatf("vec%0d", i));
        end
        // new request and changed inputs mid-transfer must not disturb the latched frame
        start(4, 8'h3C, 1'b1);
        fork
            watch(4, 8'h3C, 8'h01, 1'b0, "latched");
            begin
                repeat (30) @(negedge clk);
                drive(4, 1'b1, 8'h00, 1'b0);
                @(negedge clk);
                set_send(4, 1'b0);
            end
        join
        errs = 0;
        repeat (20) begin
            @(negedge clk);
            o = outs(4);
            if (o[2] !== 1'b1 || o[1] !== 1'b0) errs++;
        end
        chk("no_second_transfer", errs, 0);
        // send held high: second start bit must follow the done cycle directly
        start(4, 8'h5A, 1'b0);
        watch(4, 8'h5A, 8'h00, 1'b1, "cont1");
        watch(4, 8'h5A, 8'h00, 1'b0, "cont2");
        // asynchronous reset during byte0 data bits
        start(4, 8'hC3, 1'b0);
        @(negedge clk);
        set_send(4, 1'b0);
        repeat (14) @(negedge clk);
        o = outs(4);
        chk("pre_reset busy", int'(o[1]), 1);
        rst = 1'b0;
        #1;
        o = outs(4);
        chk("async_reset tx/busy/done", int'(o), 3'b100);
        @(negedge clk);
        rst = 1'b1;
        errs = 0;
        repeat (30) begin
            @(negedge clk);
            o = outs(4);
            if (o !== 3'b100) errs++;
        end
        chk("post_reset idle", errs, 0);
        for (int i = 0; i < 6; i++) begin
            cpb = (i % 2 == 0) ? 4 : 2;
            rd = 8'($urandom);
            ro = 1'($urandom_range(0, 1));
            start(cpb, rd, ro);
            watch(cpb, rd, {7'b0, ro}, 1'b0, $sformatf("rand%0d", i));
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
